// File: rtl/addsub_op_sequencer_if.sv
// Command/result handshake bundle for addsub_op_sequencer.
// The slave modport is the sequencer side; the master modport is the
// side that issues commands and consumes results.
interface addsub_op_sequencer_if;
    // Command channel
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;

    // Result channel
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_s;
    logic        out_co;
    logic        out_z;
    logic        out_n;
    logic        out_v;

    modport slave (
        input  in_valid,
        input  in_op,
        input  in_a,
        input  in_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_s,
        output out_co,
        output out_z,
        output out_n,
        output out_v
    );

    modport master (
        output in_valid,
        output in_op,
        output in_a,
        output in_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_s,
        input  out_co,
        input  out_z,
        input  out_n,
        input  out_v
    );
endinterface

// File: rtl/addsub_op_sequencer.sv
// Sequential front end for the 16-bit add_sub stage.
// Commands are accepted in IDLE, evaluated in EXEC and the registered
// result is held in HOLD until the consumer takes it. A 16-bit
// accumulator captures every completed result so that chained
// accumulate operations need no external feedback.

// Combinational 16-bit adder/subtractor: M=0 gives a+b, M=1 gives a+~b+1.
module add_sub (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        M,
    output logic [15:0] s,
    output logic        co
);
    logic [15:0] b_eff;

    assign b_eff   = M ? ~b : b;
    assign {co, s} = {1'b0, a} + {1'b0, b_eff} + {16'b0, M};
endmodule

module addsub_op_sequencer (
    input  logic                       clk,
    input  logic                       rst,
    addsub_op_sequencer_if.slave       bus,
    output logic [15:0]                acc,
    output logic [7:0]                 op_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_ACCADD = 3'b010,
        OP_ACCSUB = 3'b011,
        OP_LOAD   = 3'b100,
        OP_CLR    = 3'b101,
        OP_NOP0   = 3'b110,
        OP_NOP1   = 3'b111
    } op_e;

    // Control and latched command
    state_e      state_q;
    op_e         op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;

    // Registered outputs
    logic        in_ready_q;
    logic        out_valid_q;
    logic [15:0] out_s_q;
    logic        out_co_q;
    logic        out_z_q;
    logic        out_n_q;
    logic        out_v_q;
    logic [15:0] acc_q;
    logic [7:0]  cnt_q;

    // Adder operands and raw adder result
    logic [15:0] add_x;
    logic [15:0] add_y;
    logic        add_m;
    logic [15:0] add_s;
    logic        add_co;

    // Next values captured at the end of EXEC
    logic [15:0] res_d;
    logic        co_d;
    logic        v_d;

    // Select adder operands and mode from the latched opcode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves a
        // value unassigned, which would otherwise infer a latch.
        add_x = a_q;
        add_y = b_q;
        add_m = 1'b0;
        case (op_q)
            OP_ADD:    begin add_x = a_q;   add_m = 1'b0; end
            OP_SUB:    begin add_x = a_q;   add_m = 1'b1; end
            OP_ACCADD: begin add_x = acc_q; add_m = 1'b0; end
            OP_ACCSUB: begin add_x = acc_q; add_m = 1'b1; end
            default:   begin add_x = a_q;   add_m = 1'b0; end
        endcase
    end

    add_sub u_add_sub (
        .a  (add_x),
        .b  (add_y),
        .M  (add_m),
        .s  (add_s),
        .co (add_co)
    );

    // Pick the result, carry and overflow for the latched opcode.
    always_comb begin
        res_d = add_s;
        co_d  = add_co;
        v_d   = 1'b0;
        case (op_q)
            OP_ADD, OP_ACCADD: begin
                res_d = add_s;
                co_d  = add_co;
                v_d   = (add_x[15] == add_y[15]) && (add_s[15] != add_x[15]);
            end
            OP_SUB, OP_ACCSUB: begin
                res_d = add_s;
                co_d  = add_co;
                v_d   = (add_x[15] != add_y[15]) && (add_s[15] != add_x[15]);
            end
            OP_LOAD: begin
                res_d = a_q;
                co_d  = 1'b0;
                v_d   = 1'b0;
            end
            OP_CLR: begin
                res_d = 16'h0000;
                co_d  = 1'b0;
                v_d   = 1'b0;
            end
            default: begin
                // NOP re-presents the accumulator unchanged.
                res_d = acc_q;
                co_d  = 1'b0;
                v_d   = 1'b0;
            end
        endcase
    end

    // Control FSM with all outputs registered; reset abandons any pending op.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples values from before this edge.
        if (rst) begin
            // NOTE: command latches are reset too; they are only a few
            // flops and this keeps simulation free of X on the adder.
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_s_q     <= 16'h0000;
            out_co_q    <= 1'b0;
            out_z_q     <= 1'b0;
            out_n_q     <= 1'b0;
            out_v_q     <= 1'b0;
            acc_q       <= 16'h0000;
            cnt_q       <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op_q       <= op_e'(bus.in_op);
                        a_q        <= bus.in_a;
                        b_q        <= bus.in_b;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    out_s_q     <= res_d;
                    out_co_q    <= co_d;
                    out_z_q     <= (res_d == 16'h0000);
                    out_n_q     <= res_d[15];
                    out_v_q     <= v_d;
                    acc_q       <= res_d;
                    cnt_q       <= cnt_q + 8'd1;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_s     = out_s_q;
    assign bus.out_co    = out_co_q;
    assign bus.out_z     = out_z_q;
    assign bus.out_n     = out_n_q;
    assign bus.out_v     = out_v_q;
    assign acc           = acc_q;
    assign op_count      = cnt_q;

endmodule
